// File: rtl/ocm_noise_arbiter.sv
// ocm_noise_arbiter
// Shares one single-port noise RAM (2^ADDR_W x DATA_W, 1-cycle read latency)
// between an Avalon-MM host port and a sequential streaming reader.
// There is one RAM grant per cycle, decided by round-robin when both sides
// request. Stream read data lands in a 2-entry skid FIFO, so the consumer
// sees a plain valid/ready interface.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   host_*                Avalon-MM slave (address, byteenable, read, write,
//                         writedata, waitrequest, readdata, readdatavalid)
//   strm_start/stop       start (latches base/len/loop) and abort pulses
//   strm_base/len/loop    stream window; len==0 means the full RAM depth
//   strm_data/valid/ready stream output handshake
//   strm_busy, strm_done  FSM not idle, end-of-stream pulse (non-loop only)
//   ram_*                 RAM master side; ram_readdata is valid the cycle
//                         after the address is presented
module ocm_noise_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] host_address,
    input  logic [BE_W-1:0]   host_byteenable,
    input  logic              host_read,
    input  logic              host_write,
    input  logic [DATA_W-1:0] host_writedata,
    output logic              host_waitrequest,
    output logic [DATA_W-1:0] host_readdata,
    output logic              host_readdatavalid,
    input  logic              strm_start,
    input  logic              strm_stop,
    input  logic [ADDR_W-1:0] strm_base,
    input  logic [ADDR_W:0]   strm_len,
    input  logic              strm_loop,
    output logic [DATA_W-1:0] strm_data,
    output logic              strm_valid,
    input  logic              strm_ready,
    output logic              strm_busy,
    output logic              strm_done,
    output logic [ADDR_W-1:0] ram_address,
    output logic [BE_W-1:0]   ram_byteenable,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_writedata,
    input  logic [DATA_W-1:0] ram_readdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W:0]     issued_q, issued_d;
    logic                loop_q, loop_d;
    logic                done_q, done_d;
    logic                last_strm_q, last_strm_d;   // 1: stream won the last dual-request grant
    logic                host_rd_q, host_rd_d;       // host read data returns this cycle
    logic                strm_inflight_q, strm_inflight_d;

    logic [DATA_W-1:0]   fifo_mem_q [2];
    logic [DATA_W-1:0]   fifo_mem_d [2];
    logic                fifo_wr_q, fifo_wr_d;
    logic                fifo_rd_q, fifo_rd_d;
    logic [1:0]          fifo_count_q, fifo_count_d;

    logic                host_req;
    logic                strm_req;
    logic                gnt_host;
    logic                gnt_strm;
    logic                host_wr_gnt;
    logic                stop_act;
    logic                fifo_push;
    logic                fifo_pop;
    logic [ADDR_W:0]     issued_inc;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign host_req = host_read | host_write;
    assign stop_act = strm_stop & (state_q != ST_IDLE);
    // Entries already buffered plus the read in flight must leave room,
    // which is what makes FIFO overflow impossible.
    assign strm_req = (state_q == ST_RUN) &&
                      ((fifo_count_q + {1'b0, strm_inflight_q}) < 2'd2);

    always_comb begin
        gnt_host    = host_req;
        gnt_strm    = strm_req;
        last_strm_d = last_strm_q;
        if (host_req && strm_req) begin
            gnt_host    = last_strm_q;
            gnt_strm    = ~last_strm_q;
            last_strm_d = ~last_strm_q;
        end
    end

    assign host_wr_gnt      = gnt_host & host_write;
    assign ram_chipselect   = gnt_host | gnt_strm;
    assign ram_write        = host_wr_gnt;
    assign ram_address      = gnt_host ? host_address : (gnt_strm ? addr_q : '0);
    assign ram_byteenable   = host_wr_gnt ? host_byteenable : (gnt_strm | gnt_host ? '1 : '0);
    assign ram_writedata    = host_wr_gnt ? host_writedata : '0;
    assign host_waitrequest = host_req & ~gnt_host;

    assign host_rd_d          = gnt_host & ~host_write;
    assign host_readdatavalid = host_rd_q;
    assign host_readdata      = host_rd_q ? ram_readdata : '0;

    // A stream grant in the same cycle as a stop is dropped on return.
    assign strm_inflight_d = gnt_strm & ~stop_act;

    // ------------------------------------------------------------------
    // Skid FIFO
    // ------------------------------------------------------------------
    assign fifo_push = strm_inflight_q & ~stop_act;
    assign fifo_pop  = (fifo_count_q != 2'd0) & strm_ready;

    assign strm_valid = (fifo_count_q != 2'd0);
    assign strm_data  = strm_valid ? fifo_mem_q[fifo_rd_q] : '0;

    always_comb begin
        fifo_wr_d    = fifo_wr_q;
        fifo_rd_d    = fifo_rd_q;
        fifo_count_d = fifo_count_q;
        if (stop_act) begin
            fifo_wr_d    = 1'b0;
            fifo_rd_d    = 1'b0;
            fifo_count_d = 2'd0;
        end else begin
            if (fifo_push) begin
                fifo_wr_d = ~fifo_wr_q;
            end
            if (fifo_pop) begin
                fifo_rd_d = ~fifo_rd_q;
            end
            fifo_count_d = fifo_count_q + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            assign fifo_mem_d[gi] = (fifo_push && (fifo_wr_q == 1'(gi))) ?
                                    ram_readdata : fifo_mem_q[gi];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    fifo_mem_q[gi] <= '0;
                end else begin
                    fifo_mem_q[gi] <= fifo_mem_d[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stream FSM
    // ------------------------------------------------------------------
    assign issued_inc = issued_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        base_d   = base_q;
        len_d    = len_q;
        issued_d = issued_q;
        loop_d   = loop_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // stop beats start when both pulse together
                if (strm_start && !strm_stop) begin
                    base_d   = strm_base;
                    len_d    = (strm_len == '0) ? FULL_LEN : strm_len;
                    loop_d   = strm_loop;
                    addr_d   = strm_base;
                    issued_d = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (strm_stop) begin
                    state_d = ST_IDLE;
                end else if (gnt_strm) begin
                    addr_d   = addr_q + 1'b1;   // wraps at the RAM depth
                    issued_d = issued_inc;
                    if (issued_inc == len_q) begin
                        if (loop_q) begin
                            addr_d   = base_q;
                            issued_d = '0;
                        end else begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (strm_stop) begin
                    state_d = ST_IDLE;
                end else if ((fifo_count_q == 2'd0) && !strm_inflight_q) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign strm_busy = (state_q != ST_IDLE);
    assign strm_done = done_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            base_q          <= '0;
            len_q           <= '0;
            issued_q        <= '0;
            loop_q          <= 1'b0;
            done_q          <= 1'b0;
            last_strm_q     <= 1'b1;   // first dual request goes to the host
            host_rd_q       <= 1'b0;
            strm_inflight_q <= 1'b0;
            fifo_wr_q       <= 1'b0;
            fifo_rd_q       <= 1'b0;
            fifo_count_q    <= 2'd0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            base_q          <= base_d;
            len_q           <= len_d;
            issued_q        <= issued_d;
            loop_q          <= loop_d;
            done_q          <= done_d;
            last_strm_q     <= last_strm_d;
            host_rd_q       <= host_rd_d;
            strm_inflight_q <= strm_inflight_d;
            fifo_wr_q       <= fifo_wr_d;
            fifo_rd_q       <= fifo_rd_d;
            fifo_count_q    <= fifo_count_d;
        end
    end

endmodule

// File: tb/tb_ocm_noise_arbiter.sv
// Directed testbench for ocm_noise_arbiter. Includes a behavioural model of
// the single-port RAM (registered read, byte-enabled write) and a monitor that
// records stream pops, strm_done pulses and stream grants.
module tb_ocm_noise_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [ADDR_W-1:0] host_address = '0;
    logic [BE_W-1:0]   host_byteenable = '0;
    logic              host_read = 1'b0;
    logic              host_write = 1'b0;
    logic [DATA_W-1:0] host_writedata = '0;
    logic              host_waitrequest;
    logic [DATA_W-1:0] host_readdata;
    logic              host_readdatavalid;
    logic              strm_start = 1'b0;
    logic              strm_stop = 1'b0;
    logic [ADDR_W-1:0] strm_base = '0;
    logic [ADDR_W:0]   strm_len = '0;
    logic              strm_loop = 1'b0;
    logic [DATA_W-1:0] strm_data;
    logic              strm_valid;
    logic              strm_ready = 1'b0;
    logic              strm_busy;
    logic              strm_done;
    logic [ADDR_W-1:0] ram_address;
    logic [BE_W-1:0]   ram_byteenable;
    logic              ram_chipselect;
    logic              ram_write;
    logic [DATA_W-1:0] ram_writedata;
    logic [DATA_W-1:0] ram_readdata = '0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ocm_noise_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .host_address(host_address), .host_byteenable(host_byteenable),
        .host_read(host_read), .host_write(host_write),
        .host_writedata(host_writedata), .host_waitrequest(host_waitrequest),
        .host_readdata(host_readdata), .host_readdatavalid(host_readdatavalid),
        .strm_start(strm_start), .strm_stop(strm_stop), .strm_base(strm_base),
        .strm_len(strm_len), .strm_loop(strm_loop), .strm_data(strm_data),
        .strm_valid(strm_valid), .strm_ready(strm_ready), .strm_busy(strm_busy),
        .strm_done(strm_done), .ram_address(ram_address),
        .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_writedata(ram_writedata),
        .ram_readdata(ram_readdata)
    );

    // RAM model; preload fills word i with value i
    logic [DATA_W-1:0] ram_mem [0:1023];
    logic              preload = 1'b0;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= DATA_W'(i);
        end else if (ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
                end
            end else begin
                ram_readdata <= ram_mem[ram_address];
            end
        end
    end

    // Monitor
    logic [DATA_W-1:0] got_q[$];
    int done_cnt = 0;
    int pop_cnt = 0;
    int sgnt_cnt = 0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (strm_valid && strm_ready) begin
                got_q.push_back(strm_data);
                pop_cnt++;
            end
            if (strm_done) done_cnt++;
            if (ram_chipselect && !((host_read || host_write) && !host_waitrequest)) sgnt_cnt++;
            assert (dut.fifo_count_q <= 2'd2) else $error("fifo overflow count=%0d", dut.fifo_count_q);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic host_wr(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        bit ok = 0;
        @(posedge clk); #1;
        host_write = 1'b1; host_address = a; host_byteenable = be; host_writedata = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!host_waitrequest) begin ok = 1; break; end
        end
        check_val("wr_grant", 32'(ok), 32'd1);
        check_val("wr_ram_write", 32'(ram_write), 32'd1);
        check_val("wr_ram_be", 32'(ram_byteenable), 32'(be));
        @(posedge clk); #1;
        host_write = 1'b0;
    endtask

    task automatic host_rd(input logic [9:0] a, input logic [31:0] exp);
        bit ok = 0;
        @(posedge clk); #1;
        host_read = 1'b1; host_address = a;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!host_waitrequest) begin ok = 1; break; end
        end
        check_val("rd_grant", 32'(ok), 32'd1);
        check_val("rd_rdv_grant_cycle", 32'(host_readdatavalid), 32'd0);
        @(posedge clk); #1;
        host_read = 1'b0;
        @(negedge clk);
        check_val("rd_rdv_next_cycle", 32'(host_readdatavalid), 32'd1);
        check_val("rd_data", host_readdata, exp);
        @(negedge clk);
        check_val("rd_rdv_single", 32'(host_readdatavalid), 32'd0);
    endtask

    task automatic start_strm(input int base, input int len, input bit lp);
        @(posedge clk); #1;
        strm_base = ADDR_W'(base); strm_len = (ADDR_W+1)'(len); strm_loop = lp;
        strm_start = 1'b1;
        @(posedge clk); #1;
        strm_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim);
        bit ok = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (strm_done) begin ok = 1; break; end
        end
        check_val(tag, 32'(ok), 32'd1);
        check_val({tag, "_busy_low"}, 32'(strm_busy), 32'd0);
    endtask

    // Expected element i: (base + i % period) mod 1024
    task automatic check_seq(input string tag, input int first, input int n, input int base, input int period);
        int avail = got_q.size() - first;
        check_val({tag, "_count"}, 32'(avail < n ? avail : n), 32'(n));
        for (int i = 0; i < n && i < avail; i++) begin
            check_val($sformatf("%s[%0d]", tag, i), got_q[first + i], 32'((base + (i % period)) % 1024));
        end
    endtask

    initial begin
        int first, dsnap, late, sz;

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check_val("rst_waitrequest", 32'(host_waitrequest), 32'd0);
        check_val("rst_rdv", 32'(host_readdatavalid), 32'd0);
        check_val("rst_rdata", host_readdata, 32'd0);
        check_val("rst_valid", 32'(strm_valid), 32'd0);
        check_val("rst_busy", 32'(strm_busy), 32'd0);
        check_val("rst_done", 32'(strm_done), 32'd0);
        check_val("rst_cs", 32'(ram_chipselect), 32'd0);
        check_val("rst_write", 32'(ram_write), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        // ---- host only ----
        host_wr(10'd5, 4'b1111, 32'hDEADBEEF);
        host_rd(10'd5, 32'hDEADBEEF);
        host_wr(10'd5, 4'b0001, 32'h000000AA);
        host_rd(10'd5, 32'hDEADBEAA);

        // ---- preload word = address ----
        @(posedge clk); #1 preload = 1'b1;
        @(posedge clk); #1 preload = 1'b0;

        // ---- stream with address wrap ----
        strm_ready = 1'b1;
        first = got_q.size(); dsnap = done_cnt;
        start_strm(1020, 6, 1'b0);
        wait_done("wrap_done", 200);
        repeat (5) @(negedge clk);
        check_seq("wrap_seq", first, 6, 1020, 6);
        check_val("wrap_done_once", 32'(done_cnt - dsnap), 32'd1);

        // ---- contention: host reads every cycle ----
        first = got_q.size(); dsnap = done_cnt;
        @(posedge clk); #1;
        host_read = 1'b1; host_address = 10'd200;
        strm_base = 10'd100; strm_len = 11'd8; strm_loop = 1'b0; strm_start = 1'b1;
        @(posedge clk); #1 strm_start = 1'b0;   // T1: first dual request, host wins
        @(posedge clk); #1;                     // T2: stream, then alternating
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            check_val($sformatf("cont_wait[%0d]", k), 32'(host_waitrequest), 32'(k % 2 == 0));
            check_val($sformatf("cont_cs[%0d]", k), 32'(ram_chipselect), 32'd1);
            check_val($sformatf("cont_rdv[%0d]", k), 32'(host_readdatavalid), 32'(k % 2 == 0));
            check_val($sformatf("cont_rdata[%0d]", k), host_readdata, (k % 2 == 0) ? 32'd200 : 32'd0);
        end
        wait_done("cont_done", 100);
        @(posedge clk); #1 host_read = 1'b0;
        repeat (3) @(negedge clk);
        check_seq("cont_seq", first, 8, 100, 8);

        // ---- backpressure ----
        first = got_q.size();
        start_strm(300, 12, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk); #1 strm_ready = 1'b0;
        late = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k >= 3 && ram_chipselect) late++;
        end
        check_val("bp_late_grants", 32'(late), 32'd0);
        check_val("bp_valid_held", 32'(strm_valid), 32'd1);
        @(posedge clk); #1;
        check_val("bp_buffered", 32'((sgnt_cnt - pop_cnt) - 0), 32'(dut.fifo_count_q));
        check_val("bp_fifo_full", 32'(sgnt_cnt - pop_cnt), 32'd2);
        strm_ready = 1'b1;
        wait_done("bp_done", 200);
        repeat (3) @(negedge clk);
        check_seq("bp_seq", first, 12, 300, 12);

        // ---- loop then stop ----
        first = got_q.size(); dsnap = done_cnt;
        start_strm(10, 3, 1'b1);
        for (int i = 0; i < 100 && got_q.size() < first + 7; i++) @(negedge clk);
        @(posedge clk); #1 strm_stop = 1'b1;
        @(posedge clk); #1 strm_stop = 1'b0;
        @(negedge clk);
        check_val("stop_valid", 32'(strm_valid), 32'd0);
        check_val("stop_busy", 32'(strm_busy), 32'd0);
        sz = got_q.size();
        repeat (6) @(negedge clk);
        check_val("stop_no_more", 32'(got_q.size()), 32'(sz));
        check_val("stop_no_done", 32'(done_cnt - dsnap), 32'd0);
        check_seq("loop_seq", first, 7, 10, 3);

        // ---- len 0 = 1024 words ----
        first = got_q.size();
        start_strm(0, 0, 1'b0);
        wait_done("len0_done", 4000);
        repeat (3) @(negedge clk);
        check_seq("len0_seq", first, 1024, 0, 1024);

        // ---- async reset mid-stream ----
        strm_ready = 1'b0;
        start_strm(500, 20, 1'b0);
        repeat (5) @(negedge clk);
        @(posedge clk); #3 reset_n = 1'b0;
        #1;
        check_val("arst_valid", 32'(strm_valid), 32'd0);
        check_val("arst_busy", 32'(strm_busy), 32'd0);
        check_val("arst_data", strm_data, 32'd0);
        check_val("arst_cs", 32'(ram_chipselect), 32'd0);
        check_val("arst_ram_addr", 32'(ram_address), 32'd0);
        check_val("arst_done", 32'(strm_done), 32'd0);
        repeat (2) @(negedge clk);
        @(posedge clk); #3 reset_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_busy", 32'(strm_busy), 32'd0);
        check_val("post_rst_valid", 32'(strm_valid), 32'd0);
        strm_ready = 1'b1;
        first = got_q.size();
        start_strm(7, 2, 1'b0);
        wait_done("post_rst_done", 100);
        repeat (2) @(negedge clk);
        check_seq("post_rst_seq", first, 2, 7, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
